// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit_pkg
// Purpose  : Shared constants for the program-counter / fetch stage.
//            - next-PC select codes
//            - fetch state encodings
//            - instruction size in bytes
//            - alignment helper
// Revision : 1.0  initial release
// ============================================================================
package pc_fetch_unit_pkg;

    // Next-PC select codes. 2'b11 is reserved and behaves as sequential.
    localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
    localparam logic [1:0] PC_SRC_BR   = 2'b01;
    localparam logic [1:0] PC_SRC_JALR = 2'b10;

    // Fetch state encodings
    localparam logic [1:0] ST_START = 2'b00;
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_TRAP  = 2'b10;

    localparam int INSTR_BYTES = 4;

    // A target is word aligned when its two low bits are clear.
    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return (lsbs == 2'b00);
    endfunction

endpackage : pc_fetch_unit_pkg
`default_nettype wire

// File: rtl/pc_fetch_unit_adder.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit_adder
// Purpose  : Plain WIDTH-bit modulo adder, used to form pc + 4.
// Ports    : i_a    - first operand
//            i_b    - second operand
//            o_sum  - (i_a + i_b) mod 2^WIDTH
// Revision : 1.0  initial release
// ============================================================================
module pc_fetch_unit_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule : pc_fetch_unit_adder
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Program-counter stage. Holds the PC, selects the next PC
//            (sequential, branch/JAL, JALR), runs the request/ready fetch
//            handshake and traps on a misaligned redirect until reset.
// Ports    : clk           - clock, rising edge
//            reset         - synchronous active-high reset
//            stall         - hazard stall, blocks fetch acceptance
//            pc_src        - next-PC select (00 seq, 01 br, 10 jalr, 11 seq)
//            branch_target - target for branch/JAL
//            jalr_target   - raw rs1+imm for JALR (bit 0 is dropped)
//            imem_ready    - instruction memory accepts the request
//            fetch_req     - fetch request at address pc
//            pc            - current PC
//            pc_plus4      - pc + 4, combinational
//            fetch_fire    - accepted fetch this cycle
//            misaligned    - sticky trap flag
//            trap_pc       - offending target captured on trap
//            fetch_count   - number of accepted fetches, wraps
// Revision : 1.0  initial release
// ============================================================================
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       pc_src,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jalr_target,
    input  logic             imem_ready,
    output logic             fetch_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             fetch_fire,
    output logic             misaligned,
    output logic [WIDTH-1:0] trap_pc,
    output logic [WIDTH-1:0] fetch_count
);

    localparam logic [WIDTH-1:0] c_instr_bytes = WIDTH'(INSTR_BYTES);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_fetch_req;
    logic             r_misaligned;
    logic [WIDTH-1:0] r_trap_pc;
    logic [WIDTH-1:0] r_fetch_count;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_fire;

    pc_fetch_unit_adder #(
        .WIDTH (WIDTH)
    ) u_pc_adder (
        .i_a   (r_pc),
        .i_b   (c_instr_bytes),
        .o_sum (w_pc_plus4)
    );

    // Next-PC select. JALR drops bit 0 of the raw sum, so a target that
    // differs only in bit 0 still counts as aligned.
    always_comb begin
        w_next_pc = w_pc_plus4;
        case (pc_src)
            PC_SRC_BR:   w_next_pc = branch_target;
            PC_SRC_JALR: w_next_pc = {jalr_target[WIDTH-1:1], 1'b0};
            default:     w_next_pc = w_pc_plus4;
        endcase
    end

    // r_fetch_req is only ever set while in FETCH, so fire is
    // automatically suppressed in START and TRAP. Stall outranks ready.
    assign w_fire = r_fetch_req & imem_ready & ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_START;
            r_pc          <= RESET_PC;
            r_fetch_req   <= 1'b0;
            r_misaligned  <= 1'b0;
            r_trap_pc     <= '0;
            r_fetch_count <= '0;
        end else begin
            case (r_state)
                ST_START: begin
                    // One idle cycle after reset before the first request.
                    r_state     <= ST_FETCH;
                    r_fetch_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (w_fire) begin
                        // The faulting fetch was still accepted, so it counts.
                        r_fetch_count <= r_fetch_count + 1'b1;
                        if (is_word_aligned(w_next_pc[1:0])) begin
                            r_pc <= w_next_pc;
                        end else begin
                            r_state      <= ST_TRAP;
                            r_fetch_req  <= 1'b0;
                            r_misaligned <= 1'b1;
                            r_trap_pc    <= w_next_pc;
                        end
                    end
                end
                ST_TRAP: begin
                    // Frozen until reset.
                    r_fetch_req <= 1'b0;
                end
                default: begin
                    r_state     <= ST_START;
                    r_fetch_req <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_req   = r_fetch_req;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fetch_fire  = w_fire;
    assign misaligned  = r_misaligned;
    assign trap_pc     = r_trap_pc;
    assign fetch_count = r_fetch_count;

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Self-checking bench for pc_fetch_unit. A table of directed
//            cycles walks the main scenarios, then randomized cycles are
//            compared against a behavioural model of the fetch stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam int          c_width    = 32;
    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic        imem_ready;
    logic        fetch_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_fire;
    logic        misaligned;
    logic [31:0] trap_pc;
    logic [31:0] fetch_count;

    int n_total = 0;
    int n_pass  = 0;

    pc_fetch_unit #(
        .WIDTH    (c_width),
        .RESET_PC (c_reset_pc)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jalr_target   (jalr_target),
        .imem_ready    (imem_ready),
        .fetch_req     (fetch_req),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_fire    (fetch_fire),
        .misaligned    (misaligned),
        .trap_pc       (trap_pc),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // One directed cycle: inputs, fire expected before the edge, and the
    // outputs expected just after the edge.
    typedef struct {
        logic        rst;
        logic        stl;
        logic [1:0]  src;
        logic [31:0] br;
        logic [31:0] jr;
        logic        rdy;
        logic        fire;
        logic [31:0] epc;
        logic        ereq;
        logic        emis;
        logic [31:0] etpc;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic rst, input logic stl, input logic [1:0] src,
                       input logic [31:0] br, input logic [31:0] jr, input logic rdy,
                       input logic fire, input logic [31:0] epc, input logic ereq,
                       input logic emis, input logic [31:0] etpc, input logic [31:0] ecnt);
        vec_t v;
        v.rst = rst; v.stl = stl; v.src = src; v.br = br; v.jr = jr; v.rdy = rdy;
        v.fire = fire; v.epc = epc; v.ereq = ereq; v.emis = emis; v.etpc = etpc; v.ecnt = ecnt;
        vt.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic stl, input logic [1:0] src,
                         input logic [31:0] br, input logic [31:0] jr, input logic rdy);
        reset = rst; stall = stl; pc_src = src;
        branch_target = br; jalr_target = jr; imem_ready = rdy;
    endtask

    task automatic chk_outputs(input string tag, input logic [31:0] epc, input logic ereq,
                               input logic emis, input logic [31:0] etpc, input logic [31:0] ecnt);
        chk({tag, ".pc"},          pc,          epc);
        chk({tag, ".pc_plus4"},    pc_plus4,    epc + 32'd4);
        chk({tag, ".fetch_req"},   {31'd0, fetch_req},  {31'd0, ereq});
        chk({tag, ".misaligned"},  {31'd0, misaligned}, {31'd0, emis});
        chk({tag, ".trap_pc"},     trap_pc,     etpc);
        chk({tag, ".fetch_count"}, fetch_count, ecnt);
    endtask

    // Behavioural model of the fetch stage
    logic [31:0] m_pc;
    logic [31:0] m_tpc;
    logic [31:0] m_cnt;
    bit          m_idle_gap;   // first cycle after reset: no request yet
    bit          m_trapped;

    function automatic logic [31:0] pick_target(input logic [1:0] src, input logic [31:0] cur,
                                                input logic [31:0] br, input logic [31:0] jr);
        if (src == 2'd1) return br;
        if (src == 2'd2) return jr & ~32'd1;
        return cur + 32'd4;
    endfunction

    initial begin
        drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        imem_ready = 1'b1;
        #1;
        chk("reset.fetch_fire", {31'd0, fetch_fire}, 32'd0);
        chk_outputs("reset", c_reset_pc, 1'b0, 1'b0, 32'd0, 32'd0);

        //   rst stl src br            jalr          rdy fire pc            req mis trap_pc      count
        add(0, 0, 2'd0, 32'h0,        32'h0,       1, 0, 32'h0,        1, 0, 32'h0,   32'd0);
        add(0, 0, 2'd0, 32'h0,        32'h0,       1, 1, 32'h4,        1, 0, 32'h0,   32'd1);
        add(0, 0, 2'd0, 32'h0,        32'h0,       1, 1, 32'h8,        1, 0, 32'h0,   32'd2);
        add(0, 0, 2'd0, 32'h0,        32'h0,       1, 1, 32'hC,        1, 0, 32'h0,   32'd3);
        add(0, 0, 2'd0, 32'h0,        32'h0,       1, 1, 32'h10,       1, 0, 32'h0,   32'd4);
        // stalled / not ready: redirect inputs must be ignored
        add(0, 1, 2'd1, 32'h44,       32'h0,       1, 0, 32'h10,       1, 0, 32'h0,   32'd4);
        add(0, 1, 2'd1, 32'h44,       32'h0,       1, 0, 32'h10,       1, 0, 32'h0,   32'd4);
        add(0, 0, 2'd1, 32'h44,       32'h0,       0, 0, 32'h10,       1, 0, 32'h0,   32'd4);
        add(0, 0, 2'd1, 32'h44,       32'h0,       0, 0, 32'h10,       1, 0, 32'h0,   32'd4);
        add(0, 0, 2'd0, 32'h0,        32'h0,       1, 1, 32'h14,       1, 0, 32'h0,   32'd5);
        // redirects
        add(0, 0, 2'd1, 32'h20,       32'h0,       1, 1, 32'h20,       1, 0, 32'h0,   32'd6);
        add(0, 0, 2'd1, 32'h80,       32'h0,       1, 1, 32'h80,       1, 0, 32'h0,   32'd7);
        add(0, 0, 2'd2, 32'h0,        32'h101,     1, 1, 32'h100,      1, 0, 32'h0,   32'd8);
        add(0, 0, 2'd3, 32'h2,        32'h3,       1, 1, 32'h104,      1, 0, 32'h0,   32'd9);
        // misaligned branch -> trap, then nothing moves
        add(0, 0, 2'd1, 32'h102,      32'h0,       1, 1, 32'h104,      0, 1, 32'h102, 32'd10);
        add(0, 0, 2'd0, 32'h0,        32'h0,       1, 0, 32'h104,      0, 1, 32'h102, 32'd10);
        add(0, 0, 2'd2, 32'h0,        32'h3,       1, 0, 32'h104,      0, 1, 32'h102, 32'd10);
        // reset from trap, gap cycle, then fetch resumes
        add(1, 0, 2'd0, 32'h0,        32'h0,       1, 0, 32'h0,        0, 0, 32'h0,   32'd0);
        add(0, 0, 2'd0, 32'h0,        32'h0,       1, 0, 32'h0,        1, 0, 32'h0,   32'd0);
        // wrap at top of address space
        add(0, 0, 2'd1, 32'hFFFF_FFFC, 32'h0,      1, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,   32'd1);
        add(0, 0, 2'd0, 32'h0,        32'h0,       1, 1, 32'h0,        1, 0, 32'h0,   32'd2);
        // JALR with bit 1 set is misaligned
        add(0, 0, 2'd2, 32'h0,        32'h3,       1, 1, 32'h0,        0, 1, 32'h2,   32'd3);
        add(1, 0, 2'd0, 32'h0,        32'h0,       1, 0, 32'h0,        0, 0, 32'h0,   32'd0);

        foreach (vt[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vt[i].rst, vt[i].stl, vt[i].src, vt[i].br, vt[i].jr, vt[i].rdy);
            #1;
            chk({tag, ".fetch_fire"}, {31'd0, fetch_fire}, {31'd0, vt[i].fire});
            @(posedge clk);
            #1;
            chk_outputs(tag, vt[i].epc, vt[i].ereq, vt[i].emis, vt[i].etpc, vt[i].ecnt);
        end

        // Randomized cycles against the model. The DUT is in reset state
        // here (last table row asserted reset).
        m_pc = c_reset_pc; m_tpc = 0; m_cnt = 0; m_idle_gap = 1; m_trapped = 0;
        for (int n = 0; n < 2000; n++) begin
            logic        r_rst, r_stl, r_rdy, e_fire;
            logic [1:0]  r_src;
            logic [31:0] r_br, r_jr, tgt;
            r_rst = ($urandom_range(0, 39) == 0);
            r_stl = ($urandom_range(0, 3) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_src = 2'($urandom_range(0, 3));
            r_br  = $urandom & ~32'd3;
            if ($urandom_range(0, 15) == 0) r_br = r_br | 32'($urandom_range(1, 3));
            r_jr  = ($urandom & ~32'd3) | 32'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) r_jr = r_jr | 32'd2;
            if ($urandom_range(0, 63) == 0) r_br = 32'hFFFF_FFFC;

            drive(r_rst, r_stl, r_src, r_br, r_jr, r_rdy);
            e_fire = !m_idle_gap && !m_trapped && r_rdy && !r_stl;
            #1;
            chk("rand.fetch_fire", {31'd0, fetch_fire}, {31'd0, e_fire});

            if (r_rst) begin
                m_pc = c_reset_pc; m_tpc = 0; m_cnt = 0; m_idle_gap = 1; m_trapped = 0;
            end else if (m_idle_gap) begin
                m_idle_gap = 0;
            end else if (e_fire) begin
                m_cnt = m_cnt + 1;
                tgt = pick_target(r_src, m_pc, r_br, r_jr);
                if (tgt % 4 != 0) begin
                    m_trapped = 1;
                    m_tpc = tgt;
                end else begin
                    m_pc = tgt;
                end
            end

            @(posedge clk);
            #1;
            chk_outputs("rand", m_pc, !m_idle_gap && !m_trapped, m_trapped, m_tpc, m_cnt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pc_fetch_unit
`default_nettype wire
